serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial ripple adder: the addition counterpart to the combinational full subtractor.
//   Latches two WIDTH-bit operands plus carry-in on a start pulse.
//   Adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
//   Returns sum, carry-out and signed overflow with a one-cycle done strobe.
//   Area-lean arithmetic slave for datapaths that can trade latency for gates.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range 2..32
// PORTS
//   clk    input   1      rising-edge clock, single clock domain
//   rst_n  input   1      synchronous active-low reset
//   start  input   1      request; sampled only in IDLE or DONE
//   a      input   WIDTH  operand A, sampled with start
//   b      input   WIDTH  operand B, sampled with start
//   cin    input   1      carry-in, sampled with start
//   busy   output  1      high while bits are being processed (RUN)
//   done   output  1      one-cycle strobe: sum/cout/ovf valid
//   sum    output  WIDTH  result a+b+cin, modulo 2^WIDTH
//   cout   output  1      unsigned carry out of bit WIDTH-1
//   ovf    output  1      signed overflow = carry into MSB XOR cout
// BEHAVIOUR
//   Reset
//     - rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0.
//     - All internal shift, count and carry registers are cleared.
//     - Reset wins over every other input, including mid-RUN; a partial result is discarded.
//   FSM: IDLE -> RUN -> DONE -> IDLE/RUN
//   Start edge (E0), accepted when state is IDLE or DONE with start=1
//     - Latch a, b and cin into internal registers.
//     - Clear the bit counter; state=RUN, busy=1, done=0.
//     - sum/cout/ovf keep their old values until the final RUN edge.
//   RUN edge k (k=0..WIDTH-1)
//     - s = a_sh[0]^b_sh[0]^c.
//     - c_next = (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
//     - s shifts into the result register from the MSB side; a_sh and b_sh shift right by one.
//     - At k=WIDTH-1, capture the carry into the MSB (the c used at that edge) for ovf.
//   Final RUN edge (E0+WIDTH)
//     - sum=result, cout=c_next, ovf=c_msb_in^c_next.
//     - done=1, busy=0, state=DONE.
//   DONE (exactly one cycle)
//     - start=1: treated as a new start edge; done drops and RUN begins.
//     - Otherwise: next edge returns to IDLE with done=0.
//   Timing
//     - Latency: done is high in the cycle after edge E0+WIDTH.
//     - Back-to-back throughput: one result per WIDTH+1 cycles.
//   Result hold
//     - sum/cout/ovf hold after done until the next final RUN edge or reset.
//   Ignored inputs
//     - start while busy=1 is ignored (no queueing).
//     - Changes on a, b or cin after E0 have no effect.
//   Widths
//     - Counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//     - No X on any output after reset.
// TESTING (WIDTH=8)
//   1. a=00 b=00 cin=0, start -> done exactly 8 edges after start edge; sum=00 cout=0 ovf=0; busy high 8 cycles.
//   2. a=FF b=01 cin=0 -> sum=00 cout=1 ovf=0.
//      a=7F b=01 cin=0 -> sum=80 cout=0 ovf=1.
//   3. a=A5 b=5A cin=1 -> sum=00 cout=1 ovf=0.
//      a=80 b=80 cin=0 -> sum=00 cout=1 ovf=1.
//   4. Start during RUN, and a/b changed mid-RUN (a=12 b=34 cin=0) -> second start ignored; sum=46 cout=0.
//   5. Start asserted in the DONE cycle with a=03 b=04 -> new result sum=07 exactly 9 cycles after the previous done.
//   6. rst_n=0 at RUN edge k=3 -> next cycle busy=0 done=0 sum=00.
//      A new start after reset yields a correct result.
//   Scoreboard: 1000 random a/b/cin vectors checked against (a+b+cin) and signed-overflow reference.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first ripple adder with carry-out, signed overflow and done strobe
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic [CW-1:0] cnt;
    logic c, s, c_nx, last, load;
    always_comb begin
        s        = a_sh[0] ^ b_sh[0] ^ c;
        c_nx     = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
        res_nx   = {s, res[WIDTH-1:1]};
        last     = cnt == CW'(WIDTH - 1);
        load     = state != RUN && start;
        state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy     = state == RUN;
        done     = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                c    <= cin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                c    <= c_nx;
                res  <= res_nx;
                cnt  <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    sum  <= res_nx;
                    cout <= c_nx;
                    ovf  <= c ^ c_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against an arithmetic reference model
module tb_serial_adder;
    logic clk = 0, rst_n = 0, start = 0, cin = 0;
    logic [7:0] a = 0, b = 0;
    logic busy, done, cout, ovf;
    logic [7:0] sum;
    int n_chk = 0, n_err = 0, cyc = 0, lat, bc, done_at, prev_done;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int u, sv;
        logic o;
        u  = int'(x) + int'(y) + int'(ci);
        sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
        o  = (sv > 127) || (sv < -128);
        return {o, u[8], u[7:0]};
    endfunction

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done();
        lat = 0;
        bc  = busy;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
            bc += busy;
        end
        done_at = cyc;
    endtask

    task automatic check_res(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [9:0] r;
        r = ref_add(ta, tb, tc);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sum"}, sum, r[7:0]);
        check({tag, "_cout"}, cout, r[8]);
        check({tag, "_ovf"}, ovf, r[9]);
    endtask

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        launch(ta, tb, tc);
        wait_done();
        check({tag, "_lat"}, lat, 8);
        check_res(tag, ta, tb, tc);
    endtask

    initial begin
        logic [7:0] x, y;
        logic ci;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {sum, cout, ovf}, 0);
        @(negedge clk) rst_n = 1;

        op("t1", 8'h00, 8'h00, 0);
        check("t1_busy_cycles", bc, 8);
        @(posedge clk);
        #1;
        check("t1_done_strobe", done, 0);
        check("t1_idle_busy", busy, 0);

        op("t2a", 8'hFF, 8'h01, 0);
        op("t2b", 8'h7F, 8'h01, 0);
        op("t3a", 8'hA5, 8'h5A, 1);
        op("t3b", 8'h80, 8'h80, 0);

        launch(8'h12, 8'h34, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1; start = 1;
        repeat (2) @(posedge clk);
        #1 start = 0;
        wait_done();
        check_res("t4", 8'h12, 8'h34, 0);
        check("t4_sum46", sum, 8'h46);

        op("t5a", 8'h10, 8'h20, 0);
        prev_done = done_at;
        op("t5b", 8'h03, 8'h04, 0);
        check("t5_gap", done_at - prev_done, 9);

        launch(8'h55, 8'h66, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 0;
        @(posedge clk);
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_sum", sum, 0);
        check("t6_cout_ovf", {cout, ovf}, 0);
        @(negedge clk) rst_n = 1;
        op("t6_after", 8'h55, 8'h66, 1);

        for (int i = 0; i < 1000; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            if ($urandom_range(3) == 0) @(posedge clk);
            op("rnd", x, y, ci);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
